// File: rtl/divisor_clock_gen_if.sv
// Processor-side bundle for the divisor clock generator.
// The processor drives divisor and run; it reads back the tick, the divided clock and the status.
interface divisor_clock_gen_if #(
    parameter int DIV_W  = 32,
    parameter int TCNT_W = 16
);
    logic [DIV_W-1:0]  divisor;
    logic              run;
    logic              tick;
    logic              clk_out;
    logic              busy;
    logic              div_err;
    logic [DIV_W-1:0]  div_active;
    logic [TCNT_W-1:0] tick_count;

    modport master (
        output divisor, run,
        input  tick, clk_out, busy, div_err, div_active, tick_count
    );

    modport slave (
        input  divisor, run,
        output tick, clk_out, busy, div_err, div_active, tick_count
    );
endinterface

// File: rtl/divisor_clock_gen.sv
// Sample-enable tick and near-50% divided clock generator.
// A new divisor is only adopted at a period boundary.
//
// state | meaning
// IDLE  | stopped; cnt held at 0; flags an illegal divisor while run is requested
// LOAD  | one cycle; latch divisor, clear cnt and tick_count
// RUN   | count periods; tick and clk_out rise at each wrap
module divisor_clock_gen #(
    parameter int DIV_W   = 32,
    parameter int MIN_DIV = 2,
    parameter int TCNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    divisor_clock_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_active;
    logic [TCNT_W-1:0] tick_count;
    logic              tick;
    logic              clk_out;
    logic              busy;
    logic              div_err;
    logic              primed;

    logic              div_ok;
    logic              wrap;
    logic [DIV_W-1:0]  cnt_inc;

    assign div_ok  = bus.divisor >= DIV_W'(MIN_DIV);
    assign wrap    = cnt == (div_active - DIV_W'(1));
    assign cnt_inc = cnt + DIV_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            div_active <= '0;
            tick_count <= '0;
            tick       <= 1'b0;
            clk_out    <= 1'b0;
            busy       <= 1'b0;
            div_err    <= 1'b0;
            primed     <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    clk_out <= 1'b0;
                    primed  <= 1'b0;
                    if (bus.run && div_ok) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        div_err <= 1'b0;
                    end else begin
                        div_err <= bus.run;
                    end
                end
                LOAD: begin
                    if (!bus.run) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!div_ok) begin
                        // divisor went illegal after IDLE accepted it; never run with it
                        state   <= IDLE;
                        busy    <= 1'b0;
                        div_err <= 1'b1;
                    end else begin
                        div_active <= bus.divisor;
                        tick_count <= '0;
                        cnt        <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.run) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        cnt     <= '0;
                        clk_out <= 1'b0;
                        primed  <= 1'b0;
                    end else if (wrap) begin
                        cnt        <= '0;
                        tick       <= 1'b1;
                        clk_out    <= 1'b1;
                        primed     <= 1'b1;
                        tick_count <= tick_count + TCNT_W'(1);
                        if (div_ok) begin
                            div_active <= bus.divisor;
                            div_err    <= 1'b0;
                        end else begin
                            div_err    <= 1'b1;
                        end
                    end else begin
                        cnt     <= cnt_inc;
                        // clk_out stays low until the first tick so it never rises mid-period
                        clk_out <= primed && (cnt_inc < (div_active >> 1));
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tick       = tick;
    assign bus.clk_out    = clk_out;
    assign bus.busy       = busy;
    assign bus.div_err    = div_err;
    assign bus.div_active = div_active;
    assign bus.tick_count = tick_count;
endmodule

// File: tb/tb_divisor_clock_gen.sv
// Bench for divisor_clock_gen: tick timing is scoreboarded, clk_out and status are checked inline.
module tb_divisor_clock_gen;
    localparam int DIV_W   = 32;
    localparam int MIN_DIV = 2;
    localparam int TCNT_W  = 4;

    logic clk;
    logic reset_n;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    typedef struct {
        int     cyc;
        int     tc;
        longint da;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    divisor_clock_gen_if #(.DIV_W(DIV_W), .TCNT_W(TCNT_W)) bus ();

    divisor_clock_gen #(.DIV_W(DIV_W), .MIN_DIV(MIN_DIV), .TCNT_W(TCNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected ticks are popped at the negedge of their edge count; any other tick is spurious.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            chk("tick", longint'(bus.tick), 1);
            chk("tick_count", longint'(bus.tick_count), mon_e.tc);
            chk("div_active_at_tick", longint'(bus.div_active), mon_e.da);
        end else if (bus.tick !== 1'b0) begin
            chk("tick_spurious", longint'(bus.tick), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start(input int d, output int e0);
        bus.divisor = d;
        bus.run     = 1'b1;
        e0          = cyc + 1;
    endtask

    task automatic push_ticks(input int first, input int d, input int n, input int tc0, input longint da);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            x.cyc = first + k * d;
            x.tc  = (tc0 + k) % (1 << TCNT_W);
            x.da  = da;
            sb.push_back(x);
        end
    endtask

    task automatic check_quiet(input int from, input int to);
        for (int t = from; t <= to; t++) begin
            goto(t);
            chk("clk_out_first_period", longint'(bus.clk_out), 0);
        end
    endtask

    task automatic check_clk(input int first, input int d, input int periods);
        for (int i = 0; i < periods * d; i++) begin
            goto(first + i);
            chk("clk_out_pattern", longint'(bus.clk_out), ((i % d) < (d / 2)) ? 1 : 0);
        end
    endtask

    task automatic stop_at(input int t);
        goto(t);
        bus.run = 1'b0;
        goto(t + 1);
        chk("busy_after_stop", longint'(bus.busy), 0);
        chk("clk_out_after_stop", longint'(bus.clk_out), 0);
    endtask

    int e0;
    int c;

    initial begin
        reset_n     = 1'b0;
        bus.run     = 1'b0;
        bus.divisor = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_tick", longint'(bus.tick), 0);
        chk("rst_clk_out", longint'(bus.clk_out), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_div_err", longint'(bus.div_err), 0);
        chk("rst_div_active", longint'(bus.div_active), 0);
        chk("rst_tick_count", longint'(bus.tick_count), 0);

        // D=4: ticks at E0+5/9/13, clk_out 1,1,0,0
        start(4, e0);
        push_ticks(e0 + 5, 4, 3, 1, 4);
        goto(e0);
        chk("busy_after_start", longint'(bus.busy), 1);
        check_quiet(e0 + 1, e0 + 4);
        check_clk(e0 + 5, 4, 2);
        stop_at(e0 + 13);
        chk("tick_count_hold", longint'(bus.tick_count), 3);
        chk("div_active_hold", longint'(bus.div_active), 4);

        // D=2 and D=5
        start(2, e0);
        push_ticks(e0 + 3, 2, 3, 1, 2);
        check_quiet(e0 + 1, e0 + 2);
        check_clk(e0 + 3, 2, 3);
        stop_at(e0 + 8);

        start(5, e0);
        push_ticks(e0 + 6, 5, 4, 1, 5);
        check_quiet(e0 + 1, e0 + 5);
        check_clk(e0 + 6, 5, 3);
        stop_at(e0 + 21);

        // D=10, changed to 3 at cnt=4: current period keeps 10
        start(10, e0);
        push_ticks(e0 + 11, 3, 3, 1, 3);
        goto(e0 + 5);
        bus.divisor = 3;
        goto(e0 + 10);
        chk("div_active_before_wrap", longint'(bus.div_active), 10);
        check_clk(e0 + 11, 3, 2);
        stop_at(e0 + 17);

        // illegal divisor 1 held off in IDLE, then 6 accepted
        bus.divisor = 1;
        bus.run     = 1'b1;
        c           = cyc;
        goto(c + 1);
        chk("div_err_set", longint'(bus.div_err), 1);
        chk("busy_idle_err", longint'(bus.busy), 0);
        goto(c + 3);
        chk("div_err_held", longint'(bus.div_err), 1);
        chk("busy_idle_held", longint'(bus.busy), 0);
        bus.divisor = 6;
        e0          = c + 4;
        push_ticks(e0 + 7, 6, 2, 1, 6);
        goto(e0);
        chk("div_err_clear", longint'(bus.div_err), 0);
        chk("busy_after_fix", longint'(bus.busy), 1);
        stop_at(e0 + 13);

        // D=8, divisor 0 mid-period: period stays 8, div_err from next wrap
        start(8, e0);
        push_ticks(e0 + 9, 8, 4, 1, 8);
        goto(e0 + 10);
        bus.divisor = 0;
        goto(e0 + 16);
        chk("div_err_before_wrap", longint'(bus.div_err), 0);
        goto(e0 + 17);
        chk("div_err_at_wrap", longint'(bus.div_err), 1);
        goto(e0 + 18);
        bus.divisor = 8;
        goto(e0 + 24);
        chk("div_err_kept", longint'(bus.div_err), 1);
        goto(e0 + 25);
        chk("div_err_cleared_wrap", longint'(bus.div_err), 0);
        stop_at(e0 + 33);

        // run dropped on the same edge as a wrap
        start(4, e0);
        push_ticks(e0 + 5, 4, 2, 1, 4);
        goto(e0 + 12);
        bus.run = 1'b0;
        goto(e0 + 13);
        chk("tick_suppressed", longint'(bus.tick), 0);
        chk("busy_drop_wrap", longint'(bus.busy), 0);
        chk("clk_out_drop_wrap", longint'(bus.clk_out), 0);
        chk("tick_count_drop_wrap", longint'(bus.tick_count), 2);
        chk("div_active_drop_wrap", longint'(bus.div_active), 4);
        goto(e0 + 15);
        chk("tick_count_idle", longint'(bus.tick_count), 2);

        // async reset mid-period at D=7, then 17 ticks to wrap tick_count
        start(7, e0);
        push_ticks(e0 + 8, 7, 1, 1, 7);
        goto(e0 + 9);
        chk("clk_out_pre_reset", longint'(bus.clk_out), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_clk_out", longint'(bus.clk_out), 0);
        chk("async_rst_busy", longint'(bus.busy), 0);
        chk("async_rst_div_active", longint'(bus.div_active), 0);
        chk("async_rst_tick_count", longint'(bus.tick_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        e0      = cyc + 1;
        push_ticks(e0 + 8, 7, 17, 1, 7);
        goto(e0);
        chk("busy_post_reset", longint'(bus.busy), 1);
        check_quiet(e0 + 1, e0 + 7);
        goto(e0 + 8 + 16 * 7);
        chk("tick_count_wrapped", longint'(bus.tick_count), 1);
        stop_at(e0 + 8 + 16 * 7);

        repeat (3) @(negedge clk);
        chk("sb_empty", longint'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/divisor_clock_gen.md
Name: divisor_clock_gen

Overview:
- Consumes the 32-bit divisor word written by the processor into the divisor-clock output port.
- Generates a one-cycle sample-enable tick every `divisor` system-clock cycles, plus a near-50% duty divided clock.
- Sits between the processor's divisor register and the ADC-sampling/lock-in accumulation front end.
- Changes to the divisor take effect only at period boundaries, so the sample grid is never torn mid-period.

Parameters:
- DIV_W, 32, width of divisor input and period counter
- MIN_DIV, 2, smallest legal divisor; smaller values are rejected
- TCNT_W, 16, width of the free-running tick counter

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- divisor  in  DIV_W  requested period in clk cycles (from processor divisor register)
- run  in  1  level; 1 = generate ticks, 0 = stop
- tick  out  1  one-cycle sample-enable pulse, registered
- clk_out  out  1  divided clock, registered
- busy  out  1  high whenever state != IDLE
- div_err  out  1  high while a requested divisor is < MIN_DIV
- div_active  out  DIV_W  divisor currently in use
- tick_count  out  TCNT_W  number of ticks since last start, wraps

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (reset_n).
- Reset values:
  - state = IDLE; cnt = 0
  - tick = clk_out = busy = div_err = 0
  - div_active = 0; tick_count = 0
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - cnt held at 0; tick = 0; clk_out = 0.
  - If run = 1 and divisor >= MIN_DIV: go to LOAD.
  - If run = 1 and divisor < MIN_DIV: stay in IDLE and set div_err = 1.
  - div_err clears on the first edge where divisor >= MIN_DIV or run = 0.
- LOAD (exactly one cycle):
  - div_active <= divisor; cnt <= 0; tick_count <= 0.
  - Next state RUN.
- RUN:
  - cnt increments by 1 each edge.
  - When cnt == div_active-1: cnt <= 0 and tick <= 1 on that same edge, so tick is high for exactly one cycle.
  - Tick latency: run sampled high at edge E0 -> LOAD after E0 -> RUN after E0+1 -> first tick visible after edge E0+D+1. Later ticks follow exactly D cycles apart.
- clk_out:
  - Goes high on the same edge as tick.
  - Stays high for floor(D/2) cycles, then low for D-floor(D/2) cycles.
  - Examples: D=2 gives 1 high / 1 low; D=5 gives 2 high / 3 low.
- Divisor change while in RUN:
  - Sampled only at the wrap edge (cnt == div_active-1).
  - If divisor != div_active and divisor >= MIN_DIV, div_active <= divisor on that edge; the next period uses the new value.
  - If divisor < MIN_DIV, div_active is kept and div_err <= 1 until a valid divisor is seen at a later wrap.
  - Mid-period changes never shorten or lengthen the current period.
- run deasserted in LOAD or RUN:
  - Next edge: state = IDLE, cnt = 0, clk_out = 0, no tick issued.
  - div_active and tick_count are retained for readback.
  - If run drops on the same edge as a wrap, the tick is still suppressed.
- tick_count:
  - Increments on each tick edge; wraps from 2^TCNT_W-1 to 0 with no flag.
- busy:
  - Registered; equals 1 in LOAD and RUN.
- reset_n asserted at any time returns everything to reset values immediately. No tick or clk_out glitch is permitted after reset is released until a new LOAD.
- Arithmetic:
  - cnt is DIV_W bits and unsigned.
  - div_active-1 never underflows, because div_active >= MIN_DIV >= 2 whenever in RUN.
  - divisor = 2^DIV_W-1 is legal.

Test Plan:
- Reset, then divisor=4 with run raised at edge E0 -> busy high after E0; tick high after edges E0+5, E0+9, E0+13; clk_out pattern 1,1,0,0 repeating; tick_count 1,2,3.
- divisor=2 -> tick every 2nd cycle and clk_out toggling every cycle; divisor=5 -> tick every 5 cycles, clk_out 2 high / 3 low.
- Running at D=10, divisor changed to 3 at cnt=4 -> current period still 10 cycles; following ticks 3 cycles apart; div_active reads 3 from the wrap edge onward.
- Start with divisor=1 -> stays in IDLE, busy=0, div_err=1; divisor then set to 6 -> div_err clears, LOAD, first tick 7 cycles later. In RUN at D=8, divisor set to 0 -> period stays 8, div_err=1 from the next wrap.
- run dropped on the same edge as a wrap (D=4) -> no tick; state IDLE; clk_out 0; tick_count and div_active hold their values.
- reset_n pulsed low mid-period at D=7 -> all outputs 0 asynchronously; with run still 1 after release, first tick 8 edges after the first post-reset edge; TCNT_W=4 run for 17 ticks -> tick_count wraps to 1.
